// File: rtl/laser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : laser_pkg
// Purpose  : Shared types and default constants for the laser pulse timer.
//            - laser_state_t : controller state encoding (IDLE/ON/COOL)
//            - LASER_DEF_ON  : default pulse length when Dur == 0
//            - LASER_COOLDOWN: default dead time after each pulse
// Revision : 1.0 - initial release
// ============================================================================
package laser_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      COOL = 2'd2
   } laser_state_t;

   localparam int LASER_DEF_ON   = 16;
   localparam int LASER_COOLDOWN = 4;

endpackage : laser_pkg
`default_nettype wire

// File: rtl/laser_down_cnt.sv
`default_nettype none
// ============================================================================
// Module   : laser_down_cnt
// Purpose  : Loadable CNT_W-bit down-counter shared by the ON and COOL phases.
//            Load has priority over enable; the counter holds at zero rather
//            than wrapping.
// Ports    : Clk      - system clock, rising edge
//            Rst      - synchronous active-high reset, clears the count
//            load     - load load_val this edge
//            load_val - value to load
//            en       - decrement this edge
//            zero     - count is zero (combinational from the register)
// Revision : 1.0 - initial release
// ============================================================================
module laser_down_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - ONE;
      end
   end

   assign zero = (count == '0);

endmodule : laser_down_cnt
`default_nettype wire

// File: rtl/laser_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module   : laser_pulse_timer
// Purpose  : Single-shot laser pulse generator. One armed button press fires
//            one pulse of N cycles (N = Dur, or DEF_ON when Dur == 0),
//            followed by COOLDOWN dead cycles.
// Ports    : Clk     - system clock, rising edge
//            Rst     - synchronous active-high reset
//            B       - start button (level, synchronised)
//            Dur     - requested on-time, sampled at the start edge only
//            Abort   - cut the pulse short (LASER_ABORT_EN builds only)
//            X       - laser enable, registered
//            Busy    - state is not IDLE, registered
//            Done    - one-cycle pulse when the laser turns off
//            Aborted - one-cycle pulse with Done on early end
//                      (LASER_ABORT_EN builds only)
// Config   : define LASER_ABORT_EN to add the Abort/Aborted feature.
// Revision : 1.0 - initial release
// ============================================================================
module laser_pulse_timer
   import laser_pkg::*;
#(
   parameter int CNT_W    = 8,
   parameter int DEF_ON   = LASER_DEF_ON,
   parameter int COOLDOWN = LASER_COOLDOWN
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             B,
   input  logic [CNT_W-1:0] Dur,
`ifdef LASER_ABORT_EN
   input  logic             Abort,
   output logic             Aborted,
`endif
   output logic             X,
   output logic             Busy,
   output logic             Done
);

   // The counter holds (length - 1) so terminal count is reached on the
   // last high cycle and the value always fits in CNT_W bits.
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEF_LOAD  = CNT_W'(DEF_ON - 1);
   localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'((COOLDOWN == 0) ? 0 : COOLDOWN - 1);
   localparam bit               HAS_COOL  = (COOLDOWN != 0);

   laser_state_t     state, state_nxt;
   logic             armed, arm_nxt;
   logic             x_nxt, done_nxt, end_pulse;
   logic             cnt_load, cnt_en, cnt_zero;
   logic [CNT_W-1:0] cnt_val;
`ifdef LASER_ABORT_EN
   logic             aborted_nxt;
`endif

   laser_down_cnt #(.CNT_W(CNT_W)) u_cnt (
      .Clk      (Clk),
      .Rst      (Rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .en       (cnt_en),
      .zero     (cnt_zero)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state   <= IDLE;
         armed   <= 1'b0;
         X       <= 1'b0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
`ifdef LASER_ABORT_EN
         Aborted <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         armed   <= arm_nxt;
         X       <= x_nxt;
         Busy    <= (state_nxt != IDLE);
         Done    <= done_nxt;
`ifdef LASER_ABORT_EN
         Aborted <= aborted_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      arm_nxt   = armed;
      x_nxt     = 1'b0;
      done_nxt  = 1'b0;
      end_pulse = 1'b0;
      cnt_load  = 1'b0;
      cnt_val   = '0;
      cnt_en    = 1'b0;
`ifdef LASER_ABORT_EN
      aborted_nxt = 1'b0;
`endif

      case (state)
         IDLE: begin
            if (B && armed) begin
               state_nxt = ON;
               x_nxt     = 1'b1;
               arm_nxt   = 1'b0;
               cnt_load  = 1'b1;
               cnt_val   = (Dur == '0) ? DEF_LOAD : (Dur - ONE);
            end
         end
         ON: begin
            // Terminal count wins over Abort: a simultaneous abort is a
            // normal completion.
            if (cnt_zero) begin
               end_pulse = 1'b1;
`ifdef LASER_ABORT_EN
            end else if (Abort) begin
               end_pulse   = 1'b1;
               aborted_nxt = 1'b1;
`endif
            end else begin
               x_nxt  = 1'b1;
               cnt_en = 1'b1;
            end
            if (end_pulse) begin
               done_nxt = 1'b1;
               if (HAS_COOL) begin
                  state_nxt = COOL;
                  cnt_load  = 1'b1;
                  cnt_val   = COOL_LOAD;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         COOL: begin
            if (cnt_zero) begin
               state_nxt = IDLE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            x_nxt     = 1'b0;
         end
      endcase

      // A released button arms on any edge that leaves the block in IDLE,
      // including the edge that returns to IDLE, so a press on the first
      // IDLE edge starts the next shot.
      if (!B && (state_nxt == IDLE)) begin
         arm_nxt = 1'b1;
      end
   end

endmodule : laser_pulse_timer
`default_nettype wire

// File: tb/tb_laser_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_laser_pulse_timer
// Purpose  : Directed self-checking bench for laser_pulse_timer (default
//            parameters: CNT_W=8, DEF_ON=16, COOLDOWN=4). Abort scenarios are
//            included when LASER_ABORT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_laser_pulse_timer;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       B   = 1'b0;
   logic [7:0] Dur = 8'd0;
   logic       X, Busy, Done;
`ifdef LASER_ABORT_EN
   logic       Abort = 1'b0;
   logic       Aborted;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   // per-shot observation counters, indexed from the start edge (index 0)
   int x_cnt, busy_cnt, done_cnt, rises, first_done, last_rise, obs_idx;
   logic x_prev;

   laser_pulse_timer #(.CNT_W(8), .DEF_ON(16), .COOLDOWN(4)) dut (
      .Clk     (Clk),
      .Rst     (Rst),
      .B       (B),
      .Dur     (Dur),
`ifdef LASER_ABORT_EN
      .Abort   (Abort),
      .Aborted (Aborted),
`endif
      .X       (X),
      .Busy    (Busy),
      .Done    (Done)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clr();
      x_cnt = 0; busy_cnt = 0; done_cnt = 0; rises = 0;
      first_done = -1; last_rise = -1; obs_idx = 0; x_prev = X;
   endtask

   // Advance n edges, sampling outputs 1 time unit after each rising edge.
   task automatic observe(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge Clk); #1;
         if (X)    x_cnt++;
         if (Busy) busy_cnt++;
         if (Done) begin
            done_cnt++;
            if (first_done < 0) first_done = obs_idx;
         end
         if (X && !x_prev) begin
            rises++;
            last_rise = obs_idx;
         end
         x_prev = X;
         obs_idx++;
      end
   endtask

   initial begin
      // ---- reset ----
      clr();
      observe(2);
      Rst = 1'b0;
      chk("reset_X", int'(X), 0);
      chk("reset_Busy", int'(Busy), 0);
      chk("reset_Done", int'(Done), 0);
`ifdef LASER_ABORT_EN
      chk("reset_Aborted", int'(Aborted), 0);
`endif

      // ---- default-length shot, B held afterwards ----
      observe(2);                 // B=0 sampled in IDLE: arms
      B = 1'b1; Dur = 8'd0;
      clr();
      observe(1);
      chk("def_X_at_t0", int'(X), 1);
      chk("def_Busy_at_t0", int'(Busy), 1);
      observe(39);
      chk("def_x_cycles", x_cnt, 16);
      chk("def_busy_cycles", busy_cnt, 20);
      chk("def_done_count", done_cnt, 1);
      chk("def_done_at", first_done, 16);
      chk("def_one_pulse", rises, 1);

      // ---- Dur=3, Dur changed mid-pulse ----
      B = 1'b0;
      observe(1);
      Dur = 8'd3; B = 1'b1;
      clr();
      observe(1);
      B = 1'b0; Dur = 8'd9;
      observe(19);
      chk("dur3_x_cycles", x_cnt, 3);
      chk("dur3_done_at", first_done, 3);
      chk("dur3_busy_cycles", busy_cnt, 7);

      // ---- B held 100 cycles, then re-press after COOL ----
      Dur = 8'd0; B = 1'b1;
      clr();
      observe(100);
      chk("held_one_pulse", rises, 1);
      chk("held_x_cycles", x_cnt, 16);
      chk("held_done_count", done_cnt, 1);
      B = 1'b0;
      observe(1);
      B = 1'b1;
      clr();
      observe(1);
      B = 1'b0;
      observe(25);
      chk("repress_pulse", rises, 1);
      chk("repress_x_cycles", x_cnt, 16);

      // ---- presses during ON and COOL ignored; press at first IDLE edge ----
      Dur = 8'd5; B = 1'b1;
      clr();
      observe(1);                 // i=0 start
      B = 1'b0; observe(1);       // i=1
      B = 1'b1; observe(1);       // i=2 press in ON
      B = 1'b0; observe(4);       // i=3..6
      B = 1'b1; observe(2);       // i=7,8 press in COOL
      B = 1'b0; observe(1);       // i=9 returns to IDLE, arms
      chk("cool_busy_done", int'(Busy), 0);
      B = 1'b1; observe(1);       // i=10 earliest new start
      chk("restart_X", int'(X), 1);
      chk("restart_at", last_rise, 10);
      B = 1'b0; observe(20);
      chk("ignore_pulses", rises, 2);
      chk("ignore_x_cycles", x_cnt, 10);
      chk("ignore_done_count", done_cnt, 2);

      // ---- reset at cycle 5 of a 16-cycle pulse, B held ----
      Dur = 8'd0; B = 1'b1;
      clr();
      observe(4);                 // i=0..3
      chk("rst_pre_X", int'(X), 1);
      Rst = 1'b1;
      observe(1);                 // i=4
      chk("rst_X_drop", int'(X), 0);
      chk("rst_Busy", int'(Busy), 0);
      chk("rst_Done", int'(Done), 0);
      Rst = 1'b0;
      observe(30);
      chk("rst_no_restart", rises, 1);
      chk("rst_x_cycles", x_cnt, 4);
      chk("rst_no_done", done_cnt, 0);

`ifdef LASER_ABORT_EN
      // ---- abort at cycle 5 edge of Dur=10 ----
      B = 1'b0;
      observe(1);
      Dur = 8'd10; B = 1'b1;
      clr();
      observe(1);                 // i=0
      B = 1'b0; observe(3);       // i=1..3
      Abort = 1'b1; observe(1);   // i=4
      chk("abort_X", int'(X), 0);
      chk("abort_Done", int'(Done), 1);
      chk("abort_Aborted", int'(Aborted), 1);
      Abort = 1'b0; observe(1);   // i=5
      chk("abort_Aborted_clr", int'(Aborted), 0);
      observe(10);
      chk("abort_x_cycles", x_cnt, 4);
      chk("abort_busy_cycles", busy_cnt, 8);
      chk("abort_done_count", done_cnt, 1);

      // ---- abort at terminal count is a normal completion ----
      Dur = 8'd3; B = 1'b1;
      clr();
      observe(1);                 // i=0
      B = 1'b0; observe(2);       // i=1,2
      Abort = 1'b1; observe(1);   // i=3 terminal
      chk("tc_abort_Done", int'(Done), 1);
      chk("tc_abort_Aborted", int'(Aborted), 0);
      Abort = 1'b0;
      observe(10);
      chk("tc_abort_x_cycles", x_cnt, 3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_laser_pulse_timer
`default_nettype wire

// File: doc/laser_pulse_timer.md
# laser_pulse_timer

Parametrised single-shot laser pulse generator, the successor to the fixed 16-cycle laser timer. A button press fires one laser pulse. The pulse length is programmable per shot. A mandatory cooldown follows each pulse, and the block reports status to the surrounding control logic. It sits between the debounced button synchroniser and the laser driver output.

## Interface
- `CNT_W`, 8: counter width in bits.
- `DEF_ON`, 16: pulse length in cycles when `Dur` == 0. Range 1..2^CNT_W.
- `COOLDOWN`, 4: dead cycles after each pulse. Range 0..2^CNT_W.
- `Clk`, in, 1: system clock, rising edge.
- `Rst`, in, 1: reset, synchronous, active-high.
- `B`, in, 1: start button, level, already synchronised.
- `Dur`, in, CNT_W: requested on-time in cycles. Sampled only at the start edge.
- `Abort`, in, 1: cuts the pulse short. Present only with `LASER_ABORT_EN`.
- `X`, out, 1: laser enable, registered.
- `Busy`, out, 1: high whenever the state is not IDLE, registered.
- `Done`, out, 1: one-cycle pulse at the end of each pulse, registered.
- `Aborted`, out, 1: one-cycle pulse, coincident with `Done`, when the pulse ended early. Present only with `LASER_ABORT_EN`.

## Operation
- **Reset values:** `Rst` sampled high forces state = IDLE, `X`=0, `Busy`=0, `Done`=0, `Aborted`=0, counter=0, armed=0.
  - Reset mid-pulse drops `X` at that same edge.
  - No `Done` pulse is produced on reset.
- **Arming:** the armed flag sets on any edge where `B`=0 is sampled in IDLE.
  - A button held through reset, or held after a pulse, never retriggers.
  - Exactly one pulse is produced per press.
- **States:** IDLE → ON → COOL → IDLE.
- **IDLE:**
  - Start condition: `B`=1 and armed=1 at an edge.
  - On start: go to ON, `X`=1, clear armed, latch N.
  - N = `DEF_ON` if `Dur` == 0, otherwise `Dur`.
  - Counter loads N−1.
- **ON:**
  - Counter decrements by 1 each edge.
  - When counter == 0 at an edge: `X`=0 and `Done`=1.
  - Then go to COOL with counter = `COOLDOWN`−1, or go directly to IDLE if `COOLDOWN`=0.
- **COOL:** counter decrements each edge; at counter == 0 go to IDLE. `B` is ignored in COOL.
- **Arithmetic:** counter is CNT_W bits, unsigned. It never wraps, because terminal count is checked before decrement. `Dur`=2^CNT_W−1 is a legal maximum.
- **Input handling:** `Dur` changes while Busy have no effect on the shot in progress.

## Timing
- Start sampled at edge t0 → `X` high for cycles t0 .. t0+N−1, i.e. exactly N cycles. Latency from start edge to `X` = 0 cycles (registered at t0).
- `X` falls at edge t0+N; `Done` is high for the cycle that follows.
- State is IDLE from edge t0+N+`COOLDOWN`. The earliest next start edge is t0+N+`COOLDOWN`+1, and only if armed.
- `Busy` rises at t0 and falls at t0+N+`COOLDOWN`.

## Configuration
- Macro: `LASER_ABORT_EN`.
- **Defined:**
  - `Abort` sampled high in ON → `X`=0, `Done`=1 and `Aborted`=1 at that edge, then COOL with the full cooldown.
  - `Abort` in IDLE or COOL is ignored.
  - `Abort` at the same edge as terminal count counts as normal completion: `Done`=1, `Aborted`=0.
  - `Rst` overrides `Abort`.
- **Undefined:** the `Abort` and `Aborted` ports and their logic are absent; pulses always run the full N cycles.

## Structure
- Package `laser_pkg`:
  - state typedef: IDLE=2'd0, ON=2'd1, COOL=2'd2; default branch → IDLE with `X`=0.
  - shared default constants for `DEF_ON` and `COOLDOWN`.
- One sub-module, `laser_down_cnt`: loadable CNT_W down-counter with load, enable and zero flag. It is reused by the ON and COOL phases.

## Test plan
- Reset, then `B`=0 for 2 cycles, then `B`=1 with `Dur`=0 → `X` high exactly 16 cycles; `Done` pulses once; `Busy` high for 20 cycles.
- `Dur`=3, `B` pulsed once → `X` high 3 cycles. Changing `Dur` to 9 mid-pulse leaves the length at 3.
- `B` held high for 100 cycles after arming → exactly one pulse. Releasing and re-pressing after COOL gives a second pulse.
- `B` re-pressed during ON and during COOL → ignored. `B` released then pressed at the first IDLE edge → new pulse starts at t0+N+`COOLDOWN`+1.
- `Rst` asserted at cycle 5 of a 16-cycle pulse → `X`=0 at that edge, `Done` stays 0, and the held `B` does not restart the pulse.
- With `LASER_ABORT_EN`, `Abort` at cycle 4 of `Dur`=10 → `X` high 4 cycles, `Done`=`Aborted`=1 for one cycle, 4-cycle cooldown follows. `Abort` at the terminal count → `Aborted`=0.
